// File: rtl/sub_pipe.sv
// Pipelined signed fixed-point subtractor: aligns binary points, subtracts at full precision,
// then rounds half-up and saturates to the output format with an overflow flag.
module sub_pipe #(
  parameter int N_BITS_A = 9,
  parameter int BIN_PT_A = 6,
  parameter int N_BITS_B = 9,
  parameter int BIN_PT_B = 8,
  parameter int N_BITS_Q = 8,
  parameter int BIN_PT_Q = 5,
  parameter int LATENCY  = 2,
  localparam int WA       = N_BITS_A - BIN_PT_A,
  localparam int WB       = N_BITS_B - BIN_PT_B,
  localparam int BIN_PT_D = (BIN_PT_A > BIN_PT_B) ? BIN_PT_A : BIN_PT_B,
  localparam int N_BITS_D = ((WA > WB) ? WA : WB) + BIN_PT_D + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                in_valid,
  input  logic [N_BITS_A-1:0] a,
  input  logic [N_BITS_B-1:0] b,
  output logic                out_valid,
  output logic [N_BITS_D-1:0] diff,
  output logic [N_BITS_Q-1:0] q,
  output logic                ovf
);

  localparam int          ShA  = BIN_PT_D - BIN_PT_A;
  localparam int          ShB  = BIN_PT_D - BIN_PT_B;
  localparam int unsigned S    = BIN_PT_D - BIN_PT_Q;
  localparam int unsigned RndC = (S > 0) ? (32'd1 << (S - 1)) : 32'd0;
  // One extra MSB so the rounding increment cannot wrap at the maximum value.
  localparam int          RW   = N_BITS_D + 1;
  localparam int          CW   = (RW > N_BITS_Q) ? RW : N_BITS_Q + 1;
  localparam int          NS   = LATENCY - 1;

  localparam logic signed [CW-1:0] QMax = CW'((64'sd1 <<< (N_BITS_Q - 1)) - 64'sd1);
  localparam logic signed [CW-1:0] QMin = ~QMax;

  // Stage 1 state
  logic                v1_q;
  logic [N_BITS_D-1:0] d1_d, d1_q;

  // Stage 2..LATENCY state; index NS-1 drives the outputs
  logic                vld_q  [NS];
  logic [N_BITS_D-1:0] diff_q [NS];
  logic [N_BITS_Q-1:0] q_q    [NS];
  logic                ovf_q  [NS];

  logic [N_BITS_D-1:0] a_ext, b_ext;
  logic [RW-1:0]       rnd_sum;
  logic signed [RW-1:0] rnd_s;
  logic signed [CW-1:0] res_ext, res;
  logic [N_BITS_Q-1:0] q_d;
  logic                ovf_d;

  always_comb begin
    a_ext = {{(N_BITS_D - N_BITS_A){a[N_BITS_A-1]}}, a};
    b_ext = {{(N_BITS_D - N_BITS_B){b[N_BITS_B-1]}}, b};
    d1_d  = (a_ext << ShA) - (b_ext << ShB);
  end

  always_comb begin
    rnd_sum = {d1_q[N_BITS_D-1], d1_q} + RW'(RndC);
    rnd_s   = $signed(rnd_sum);
    res_ext = CW'(rnd_s);
    res     = res_ext >>> S;
    q_d     = res[N_BITS_Q-1:0];
    ovf_d   = 1'b0;
    if (res > QMax) begin
      q_d   = QMax[N_BITS_Q-1:0];
      ovf_d = 1'b1;
    end else if (res < QMin) begin
      q_d   = QMin[N_BITS_Q-1:0];
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      d1_q <= '0;
      for (int i = 0; i < NS; i++) begin
        vld_q[i]  <= 1'b0;
        diff_q[i] <= '0;
        q_q[i]    <= '0;
        ovf_q[i]  <= 1'b0;
      end
    end else if (ce) begin
      v1_q      <= in_valid;
      d1_q      <= d1_d;
      vld_q[0]  <= v1_q;
      diff_q[0] <= d1_q;
      q_q[0]    <= q_d;
      ovf_q[0]  <= ovf_d;
      for (int i = 1; i < NS; i++) begin
        vld_q[i]  <= vld_q[i-1];
        diff_q[i] <= diff_q[i-1];
        q_q[i]    <= q_q[i-1];
        ovf_q[i]  <= ovf_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[NS-1];
  assign diff      = diff_q[NS-1];
  assign q         = q_q[NS-1];
  assign ovf       = ovf_q[NS-1];

endmodule

// File: tb/tb_sub_pipe.sv
// Bench for sub_pipe: default (LATENCY=2) and LATENCY=4 instances share stimulus and are
// checked every cycle against an arithmetic reference model plus directed literal vectors.
module tb_sub_pipe;

  typedef struct {
    int          due;
    logic [11:0] d;
    logic [7:0]  q;
    logic        o;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, ce, in_valid;
  logic [8:0] a, b;

  logic        ov2, ovf2, ov4, ovf4;
  logic [11:0] diff2, diff4;
  logic [7:0]  q2, q4;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   ecnt   = 0;
  bit   chk_en = 1'b0;
  exp_t mq2[$];
  exp_t mq4[$];

  always #5 clk = ~clk;

  sub_pipe u_dut2 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(ov2), .diff(diff2), .q(q2), .ovf(ovf2)
  );

  sub_pipe #(.LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(ov4), .diff(diff4), .q(q4), .ovf(ovf4)
  );

  // a has 6 fractional bits, b has 8; the difference has 8, q has 5.
  function automatic exp_t model(input logic [8:0] av, input logic [8:0] bv);
    exp_t e;
    int   ai, bi, dv, r;
    ai  = int'($signed(av));
    bi  = int'($signed(bv));
    dv  = ai * 4 - bi;
    r   = (dv + 4) >>> 3;
    e.d = dv[11:0];
    e.o = 1'b0;
    if (r > 127) begin
      e.q = 8'h7f;
      e.o = 1'b1;
    end else if (r < -128) begin
      e.q = 8'h80;
      e.o = 1'b1;
    end else begin
      e.q = r[7:0];
    end
    e.due = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: counts enabled edges; a sample accepted at enabled edge E is due after
  // enabled edge E+LATENCY-1. Reset discards everything in flight.
  initial forever begin
    exp_t e;
    @(posedge clk);
    if (rst) begin
      mq2.delete();
      mq4.delete();
    end else if (ce) begin
      ecnt++;
      if (in_valid) begin
        e     = model(a, b);
        e.due = ecnt + 1;
        mq2.push_back(e);
        e.due = ecnt + 3;
        mq4.push_back(e);
      end
    end
  end

  initial forever begin
    bit ev;
    @(negedge clk);
    if (chk_en) begin
      while (mq2.size() > 0 && mq2[0].due < ecnt) void'(mq2.pop_front());
      ev = (mq2.size() > 0) && (mq2[0].due == ecnt);
      chk("dut2 out_valid", 32'(ov2), 32'(ev));
      if (ev) begin
        chk("dut2 diff", 32'(diff2), 32'(mq2[0].d));
        chk("dut2 q", 32'(q2), 32'(mq2[0].q));
        chk("dut2 ovf", 32'(ovf2), 32'(mq2[0].o));
      end
      while (mq4.size() > 0 && mq4[0].due < ecnt) void'(mq4.pop_front());
      ev = (mq4.size() > 0) && (mq4[0].due == ecnt);
      chk("dut4 out_valid", 32'(ov4), 32'(ev));
      if (ev) begin
        chk("dut4 diff", 32'(diff4), 32'(mq4[0].d));
        chk("dut4 q", 32'(q4), 32'(mq4[0].q));
        chk("dut4 ovf", 32'(ovf4), 32'(mq4[0].o));
      end
    end
  end

  task automatic chk_idle(input string nm);
    chk({nm, " dut2 out_valid"}, 32'(ov2), 32'd0);
    chk({nm, " dut2 diff"}, 32'(diff2), 32'd0);
    chk({nm, " dut2 q"}, 32'(q2), 32'd0);
    chk({nm, " dut2 ovf"}, 32'(ovf2), 32'd0);
    chk({nm, " dut4 out_valid"}, 32'(ov4), 32'd0);
    chk({nm, " dut4 q"}, 32'(q4), 32'd0);
    chk({nm, " dut4 diff"}, 32'(diff4), 32'd0);
  endtask

  // One sample with hand-computed expectations, checked on the LATENCY=2 instance.
  task automatic apply(input string nm, input logic [8:0] av, input logic [8:0] bv,
                       input logic [11:0] xd, input logic [7:0] xq, input logic xo);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, " out_valid"}, 32'(ov2), 32'd1);
    chk({nm, " diff"}, 32'(diff2), 32'(xd));
    chk({nm, " q"}, 32'(q2), 32'(xq));
    chk({nm, " ovf"}, 32'(ovf2), 32'(xo));
  endtask

  task automatic drive(input logic v, input logic [8:0] av, input logic [8:0] bv);
    in_valid = v;
    a        = av;
    b        = bv;
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    ce       = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    apply("basic", 9'h040, 9'h080, 12'h080, 8'h10, 1'b0);
    apply("tie_up", 9'h000, 9'h1fc, 12'h004, 8'h01, 1'b0);
    apply("neg_half", 9'h000, 9'h004, 12'hffc, 8'h00, 1'b0);
    apply("pos_sat", 9'h0ff, 9'h100, 12'h4fc, 8'h7f, 1'b1);
    apply("neg_sat", 9'h100, 9'h0ff, 12'hb01, 8'h80, 1'b1);
    repeat (4) @(negedge clk);

    // Stall mid-stream; inputs offered while ce=0 must be ignored.
    drive(1'b1, 9'h040, 9'h080);
    drive(1'b1, 9'h0ff, 9'h100);
    ce = 1'b0;
    drive(1'b1, 9'h123, 9'h045);
    drive(1'b1, 9'h0aa, 9'h155);
    drive(1'b1, 9'h011, 9'h1ee);
    chk("stall hold out_valid", 32'(ov2), 32'd1);
    chk("stall hold diff", 32'(diff2), 32'h080);
    ce = 1'b1;
    drive(1'b1, 9'h100, 9'h0ff);
    drive(1'b1, 9'h000, 9'h1fc);
    drive(1'b0, 9'h000, 9'h000);
    repeat (6) @(negedge clk);

    // Reset with two samples in flight and ce low.
    drive(1'b1, 9'h07f, 9'h033);
    drive(1'b1, 9'h1c0, 9'h0c0);
    in_valid = 1'b0;
    ce       = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    chk_idle("mid_reset");
    rst = 1'b0;
    ce  = 1'b1;
    repeat (6) @(negedge clk);

    // Back-to-back random traffic, exercising both latencies.
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 9'($urandom_range(511)), 9'($urandom_range(511)));
    end
    drive(1'b0, 9'h000, 9'h000);
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
